multicycle_ctrl: RTL

- Multicycle RV32I control FSM, directly upstream of the datapath ALU.
- Decodes opcode/funct fields and sequences fetch, decode, execute, memory and writeback.
- Drives the ALU's 4-bit `ALU_ctr` and operand-select muxes, and consumes the ALU `zero` flag to resolve branches.
- Also produces all register-file, memory, PC and IR enables.

---
 rtl/rv_ctrl_pkg.sv | 49 ++++
 rtl/multicycle_ctrl_if.sv | 31 +++
 rtl/alu_decoder.sv | 55 +++++
 rtl/multicycle_ctrl.sv | 174 +++++++++++++++++
 4 files changed

// File: rtl/rv_ctrl_pkg.sv
// Shared encodings for the multicycle RV32I controller: ALU ops, opcodes,
// FSM states and the operand/result select codes seen by the datapath.
package rv_ctrl_pkg;

  localparam logic [3:0] ALU_ADD  = 4'd0;
  localparam logic [3:0] ALU_SUB  = 4'd1;
  localparam logic [3:0] ALU_AND  = 4'd2;
  localparam logic [3:0] ALU_OR   = 4'd3;
  localparam logic [3:0] ALU_XOR  = 4'd4;
  localparam logic [3:0] ALU_SLL  = 4'd5;
  localparam logic [3:0] ALU_SRL  = 4'd6;
  localparam logic [3:0] ALU_SLT  = 4'd7;
  localparam logic [3:0] ALU_BEQ  = 4'd8;
  localparam logic [3:0] ALU_BNE  = 4'd9;
  localparam logic [3:0] ALU_BLT  = 4'd10;
  localparam logic [3:0] ALU_BGE  = 4'd11;
  localparam logic [3:0] ALU_BLTU = 4'd12;
  localparam logic [3:0] ALU_BGEU = 4'd13;

  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_I      = 7'b0010011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_LUI    = 7'b0110111;

  localparam logic [1:0] A_PC    = 2'd0;
  localparam logic [1:0] A_OLDPC = 2'd1;
  localparam logic [1:0] A_RS1   = 2'd2;
  localparam logic [1:0] A_ZERO  = 2'd3;

  localparam logic [1:0] B_RS2  = 2'd0;
  localparam logic [1:0] B_IMM  = 2'd1;
  localparam logic [1:0] B_FOUR = 2'd2;

  localparam logic [1:0] RES_ALUOUT = 2'd0;
  localparam logic [1:0] RES_MEM    = 2'd1;
  localparam logic [1:0] RES_ALU    = 2'd2;

  typedef enum logic [3:0] {
    S_FETCH, S_DECODE, S_MEM_ADR, S_MEM_READ, S_MEM_WB, S_MEM_WRITE, S_EXEC_R,
    S_EXEC_I, S_ALU_WB, S_BRANCH, S_JAL, S_JALR, S_LUI, S_TRAP
  } state_e;

  typedef enum logic [1:0] {CLS_NONE, CLS_R, CLS_I, CLS_BR} alu_cls_e;

endpackage

// File: rtl/multicycle_ctrl_if.sv
// Controller <-> datapath bundle: instruction fields and flags in, enables and selects out.
interface multicycle_ctrl_if;
  logic [6:0] opcode;
  logic [2:0] funct3;
  logic       funct7b5;
  logic       zero;
  logic       mem_ready;
  logic       pc_write;
  logic       ir_write;
  logic       adr_src;
  logic       mem_read;
  logic       mem_write;
  logic       reg_write;
  logic [1:0] alu_src_a;
  logic [1:0] alu_src_b;
  logic [1:0] result_src;
  logic [3:0] alu_ctr;
  logic       illegal;

  modport master (
    input  opcode, funct3, funct7b5, zero, mem_ready,
    output pc_write, ir_write, adr_src, mem_read, mem_write, reg_write,
           alu_src_a, alu_src_b, result_src, alu_ctr, illegal
  );

  modport slave (
    output opcode, funct3, funct7b5, zero, mem_ready,
    input  pc_write, ir_write, adr_src, mem_read, mem_write, reg_write,
           alu_src_a, alu_src_b, result_src, alu_ctr, illegal
  );
endinterface

// File: rtl/alu_decoder.sv
// Combinational funct decode: maps the executing state class and funct bits
// to an ALU op code, flagging combinations this core does not implement.
module alu_decoder
  import rv_ctrl_pkg::*;
(
  input  alu_cls_e   i_cls,
  input  logic [2:0] i_funct3,
  input  logic       i_funct7b5,
  output logic [3:0] o_alu_ctr,
  output logic       o_illegal
);

  always_comb begin
    o_alu_ctr = ALU_ADD;
    o_illegal = 1'b0;
    case (i_cls)
      CLS_R, CLS_I: begin
        case (i_funct3)
          3'b000: begin
            // funct7b5 only selects SUB for register-register ops
            if (i_cls == CLS_R && i_funct7b5) o_alu_ctr = ALU_SUB;
            else                              o_alu_ctr = ALU_ADD;
          end
          3'b001: o_alu_ctr = ALU_SLL;
          3'b010: o_alu_ctr = ALU_SLT;
          3'b011: o_illegal = 1'b1;
          3'b100: o_alu_ctr = ALU_XOR;
          3'b101: begin
            if (i_funct7b5) o_illegal = 1'b1;
            else            o_alu_ctr = ALU_SRL;
          end
          3'b110: o_alu_ctr = ALU_OR;
          3'b111: o_alu_ctr = ALU_AND;
          default: o_illegal = 1'b1;
        endcase
      end
      CLS_BR: begin
        case (i_funct3)
          3'b000: o_alu_ctr = ALU_BEQ;
          3'b001: o_alu_ctr = ALU_BNE;
          3'b100: o_alu_ctr = ALU_BLT;
          3'b101: o_alu_ctr = ALU_BGE;
          3'b110: o_alu_ctr = ALU_BLTU;
          3'b111: o_alu_ctr = ALU_BGEU;
          default: o_illegal = 1'b1;
        endcase
      end
      default: begin
        o_alu_ctr = ALU_ADD;
        o_illegal = 1'b0;
      end
    endcase
  end

endmodule

// File: rtl/multicycle_ctrl.sv
// Multicycle RV32I control FSM. Define CTRL_MEM_WAIT_EN to make memory states
// wait on mem_ready, trapping after MEM_TIMEOUT idle cycles.
module multicycle_ctrl
  import rv_ctrl_pkg::*;
#(
  parameter int MEM_TIMEOUT = 255
) (
  input  logic              clk,
  input  logic              reset,
  multicycle_ctrl_if.master bus
);

  state_e     r_state, w_next;
  alu_cls_e   w_cls;
  logic [3:0] w_dec_ctr;
  logic       w_dec_ill;
  logic       w_ready, w_wait_trap;
  logic       w_pc_write, w_ir_write, w_adr_src, w_mem_read, w_mem_write, w_reg_write;
  logic [1:0] w_src_a, w_src_b, w_res;
  logic [3:0] w_alu_ctr;

  if (MEM_TIMEOUT < 1) begin : g_bad_timeout
    $error("MEM_TIMEOUT must be at least 1");
  end

`ifdef CTRL_MEM_WAIT_EN
  localparam int CW = $clog2(MEM_TIMEOUT + 1);
  logic [CW-1:0] r_wait_cnt;
  logic          w_mem_state;

  assign w_mem_state = (r_state == S_FETCH) || (r_state == S_MEM_READ) || (r_state == S_MEM_WRITE);
  assign w_ready     = bus.mem_ready;
  assign w_wait_trap = w_mem_state && !bus.mem_ready && (32'(r_wait_cnt) >= MEM_TIMEOUT - 1);

  // Wait counter restarts whenever the state changes
  always_ff @(posedge clk or posedge reset) begin
    if (reset)                                              r_wait_cnt <= '0;
    else if (w_mem_state && !bus.mem_ready && w_next == r_state) r_wait_cnt <= r_wait_cnt + 1'b1;
    else                                                    r_wait_cnt <= '0;
  end
`else
  logic w_unused_mem_ready;
  assign w_unused_mem_ready = bus.mem_ready;
  assign w_ready            = 1'b1;
  assign w_wait_trap        = 1'b0;
`endif

  always_comb begin
    case (r_state)
      S_EXEC_R: w_cls = CLS_R;
      S_EXEC_I: w_cls = CLS_I;
      S_BRANCH: w_cls = CLS_BR;
      default:  w_cls = CLS_NONE;
    endcase
  end

  alu_decoder u_alu_decoder (
    .i_cls      (w_cls),
    .i_funct3   (bus.funct3),
    .i_funct7b5 (bus.funct7b5),
    .o_alu_ctr  (w_dec_ctr),
    .o_illegal  (w_dec_ill)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) r_state <= S_FETCH;
    else       r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_FETCH: begin
        if (w_wait_trap)  w_next = S_TRAP;
        else if (w_ready) w_next = S_DECODE;
        else              w_next = S_FETCH;
      end
      S_DECODE: begin
        case (bus.opcode)
          OP_LOAD, OP_STORE: w_next = S_MEM_ADR;
          OP_R:              w_next = S_EXEC_R;
          OP_I:              w_next = S_EXEC_I;
          OP_BRANCH:         w_next = S_BRANCH;
          OP_JAL:            w_next = S_JAL;
          OP_JALR:           w_next = S_JALR;
          OP_LUI:            w_next = S_LUI;
          default:           w_next = S_TRAP;
        endcase
      end
      S_MEM_ADR: begin
        if (bus.opcode == OP_LOAD) w_next = S_MEM_READ;
        else                       w_next = S_MEM_WRITE;
      end
      S_MEM_READ: begin
        if (w_wait_trap)  w_next = S_TRAP;
        else if (w_ready) w_next = S_MEM_WB;
        else              w_next = S_MEM_READ;
      end
      S_MEM_WRITE: begin
        if (w_wait_trap)  w_next = S_TRAP;
        else if (w_ready) w_next = S_FETCH;
        else              w_next = S_MEM_WRITE;
      end
      S_MEM_WB, S_ALU_WB, S_JAL: w_next = S_FETCH;
      S_EXEC_R, S_EXEC_I: w_next = w_dec_ill ? S_TRAP : S_ALU_WB;
      S_BRANCH:           w_next = w_dec_ill ? S_TRAP : S_FETCH;
      S_JALR:             w_next = S_JAL;
      S_LUI:              w_next = S_ALU_WB;
      S_TRAP:             w_next = S_TRAP;
      default:            w_next = S_FETCH;
    endcase
  end

  always_comb begin
    w_pc_write  = 1'b0;
    w_ir_write  = 1'b0;
    w_adr_src   = 1'b0;
    w_mem_read  = 1'b0;
    w_mem_write = 1'b0;
    w_reg_write = 1'b0;
    w_src_a     = A_PC;
    w_src_b     = B_RS2;
    w_res       = RES_ALUOUT;
    w_alu_ctr   = ALU_ADD;
    case (r_state)
      S_FETCH: begin
        w_mem_read = 1'b1;
        w_ir_write = w_ready;
        w_pc_write = w_ready;
        w_src_b    = B_FOUR;
        w_res      = RES_ALU;
      end
      S_DECODE:    begin w_src_a = A_OLDPC; w_src_b = B_IMM; end
      S_MEM_ADR:   begin w_src_a = A_RS1;   w_src_b = B_IMM; end
      S_MEM_READ:  begin w_mem_read = 1'b1;  w_adr_src = 1'b1; end
      S_MEM_WB:    begin w_reg_write = 1'b1; w_res = RES_MEM; end
      S_MEM_WRITE: begin w_mem_write = 1'b1; w_adr_src = 1'b1; end
      S_EXEC_R:    begin w_src_a = A_RS1; w_src_b = B_RS2; w_alu_ctr = w_dec_ctr; end
      S_EXEC_I:    begin w_src_a = A_RS1; w_src_b = B_IMM; w_alu_ctr = w_dec_ctr; end
      S_ALU_WB:    w_reg_write = 1'b1;
      S_BRANCH: begin
        // ALU reports 1 when the condition holds, so zero=0 means taken
        w_src_a    = A_RS1;
        w_src_b    = B_RS2;
        w_alu_ctr  = w_dec_ctr;
        w_pc_write = !bus.zero && !w_dec_ill;
      end
      S_JAL: begin
        w_src_a     = A_OLDPC;
        w_src_b     = B_FOUR;
        w_res       = RES_ALU;
        w_reg_write = 1'b1;
        w_pc_write  = 1'b1;
      end
      S_JALR:  begin w_src_a = A_RS1;  w_src_b = B_IMM; end
      S_LUI:   begin w_src_a = A_ZERO; w_src_b = B_IMM; end
      S_TRAP:  w_alu_ctr = ALU_ADD;
      default: w_alu_ctr = ALU_ADD;
    endcase
  end

  assign bus.pc_write   = w_pc_write  & ~reset;
  assign bus.ir_write   = w_ir_write  & ~reset;
  assign bus.mem_read   = w_mem_read  & ~reset;
  assign bus.mem_write  = w_mem_write & ~reset;
  assign bus.reg_write  = w_reg_write;
  assign bus.adr_src    = w_adr_src;
  assign bus.alu_src_a  = w_src_a;
  assign bus.alu_src_b  = w_src_b;
  assign bus.result_src = w_res;
  assign bus.alu_ctr    = w_alu_ctr;
  assign bus.illegal    = (r_state == S_TRAP);

endmodule
